alu_operand_stage: RTL

//  Issue stage directly upstream of the ALU. It accepts a 32-bit RV32I OP/OP-IMM instruction and decodes it into alu_fn_t fn, funct7_t funct7 and operands a/b.

---
 rtl/alu_operand_stage.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Issue stage in front of the ALU. Decodes an RV32I OP / OP-IMM instruction
//   into an ALU function, a funct7 qualifier, and operands a/b. Source
//   operands come from an internal 32-entry register file that has its own
//   writeback port. Decoded results are held in a one-deep output register
//   behind a valid/ready handshake, so the ALU sees flop outputs only.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  instruction handshake (in_ready is combinational)
//   in_instr           32-bit instruction word
//   wb_en/addr/data    register file write port (x0 writes are dropped)
//   out_valid/ready    operand handshake towards the ALU
//   fn, funct7         ALU function (instr[14:12]) and ADD_SRL / SUB_SRA
//   a, b               operand A (rs1) and operand B (rs2 or immediate)
//   out_rd             destination register for downstream writeback
//   out_illegal        instruction is not a decodable ALU operation
module alu_operand_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       fn,
  output logic [6:0]       funct7,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [4:0]       out_rd,
  output logic             out_illegal
);

  typedef enum logic [2:0] {
    ADD_SUB = 3'b000, SLL = 3'b001, SLT = 3'b010, SLTU = 3'b011,
    FN_XOR  = 3'b100, SRL_SRA = 3'b101, FN_OR = 3'b110, FN_AND = 3'b111
  } alu_fn_t;

  typedef enum logic [6:0] {
    ADD_SRL = 7'h00,
    SUB_SRA = 7'h20
  } funct7_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // Register file
  logic [WIDTH-1:0] rf_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Decode: field extraction and operand read with writeback bypass
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       f7;
  logic [4:0]       rs1, rs2, rd;
  logic [WIDTH-1:0] rs1_val, rs2_val;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign f7     = in_instr[31:25];

  // x0 is hard-wired; a same-cycle write to the source is forwarded.
  assign rs1_val = (rs1 == 5'd0) ? '0 :
                   (wb_en && (wb_addr == rs1)) ? wb_data : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 :
                   (wb_en && (wb_addr == rs2)) ? wb_data : rf_q[rs2];

  logic             dec_legal;
  logic             dec_use_f7;
  logic [WIDTH-1:0] dec_b;

  always_comb begin
    dec_legal  = 1'b0;
    dec_use_f7 = 1'b0;
    dec_b      = '0;
    case (opcode)
      OPC_OP: begin
        dec_legal  = (f7 == ADD_SRL) ||
                     ((f7 == SUB_SRA) && ((funct3 == ADD_SUB) || (funct3 == SRL_SRA)));
        dec_use_f7 = 1'b1;
        dec_b      = rs2_val;
      end
      OPC_OP_IMM: begin
        if (funct3 == SLL) begin
          dec_legal  = (f7 == ADD_SRL);
          dec_use_f7 = 1'b1;
          dec_b      = {{(WIDTH-5){1'b0}}, in_instr[24:20]};
        end else if (funct3 == SRL_SRA) begin
          dec_legal  = (f7 == ADD_SRL) || (f7 == SUB_SRA);
          dec_use_f7 = 1'b1;
          dec_b      = {{(WIDTH-5){1'b0}}, in_instr[24:20]};
        end else begin
          // ADDI and friends never take the subtract/arith qualifier.
          dec_legal  = 1'b1;
          dec_b      = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Output register stage
  logic             vld_q, vld_d;
  alu_fn_t          fn_q, fn_d;
  funct7_t          f7_q, f7_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [4:0]       rd_q, rd_d;
  logic             ill_q, ill_d;
  logic             accept;

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    vld_d = vld_q;
    fn_d  = fn_q;
    f7_d  = f7_q;
    a_d   = a_q;
    b_d   = b_q;
    rd_d  = rd_q;
    ill_d = ill_q;
    if (accept) begin
      vld_d = 1'b1;
      ill_d = !dec_legal;
      // Illegal instructions still flow through, but carry neutral fields.
      if (dec_legal) begin
        fn_d = alu_fn_t'(funct3);
        f7_d = dec_use_f7 ? funct7_t'(f7) : ADD_SRL;
        a_d  = rs1_val;
        b_d  = dec_b;
        rd_d = rd;
      end else begin
        fn_d = ADD_SUB;
        f7_d = ADD_SRL;
        a_d  = '0;
        b_d  = '0;
        rd_d = 5'd0;
      end
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      fn_q  <= ADD_SUB;
      f7_q  <= ADD_SRL;
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= 5'd0;
      ill_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      fn_q  <= fn_d;
      f7_q  <= f7_d;
      a_q   <= a_d;
      b_q   <= b_d;
      rd_q  <= rd_d;
      ill_q <= ill_d;
    end
  end

  assign out_valid   = vld_q;
  assign fn          = fn_q;
  assign funct7      = f7_q;
  assign a           = a_q;
  assign b           = b_q;
  assign out_rd      = rd_q;
  assign out_illegal = ill_q;

endmodule
